// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the IF/DM memory arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM: one access outstanding at a time.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_e;

    // Consecutive DM grants tolerated while a fetch is waiting.
    localparam int STARVE_LIMIT_DEFAULT = 4;

    // Launched access as held for the whole memory transaction (34 bits).
    // rd marks accesses whose completion data must be captured.
    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } access_t;

endpackage

// File: rtl/mem_arbiter_latch.sv
// Holds the launched access (rd, wr, addr, wdata) for the memory's busy window.
module arb_latch
    import mem_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  access_t d,
    output access_t q
);

    logic [15:0] ctrl_q;
    logic [13:0] ctrl_unused;

    register_16bits u_addr (
        .clk (clk), .rst (rst), .en (en), .d (d.addr), .q (q.addr)
    );

    register_16bits u_wdata (
        .clk (clk), .rst (rst), .en (en), .d (d.wdata), .q (q.wdata)
    );

    // Control bits share one cell; the upper bits are zero-filled spares.
    register_16bits u_ctrl (
        .clk (clk), .rst (rst), .en (en), .d ({14'b0, d.rd, d.wr}), .q (ctrl_q)
    );

    assign {ctrl_unused, q.rd, q.wr} = ctrl_q;

endmodule

// File: rtl/register_16bits.sv
// Generic 16-bit register cell with load enable and synchronous clear.
module register_16bits (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] q
);

    // Load on enable; synchronous clear dominates.
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (IF) and data (DM) requests onto one multi-cycle memory.
// DM wins ties unless IF has been passed over STARVE_LIMIT times in a row.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    input  logic        if_flush,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        if_done,
    output logic [15:0] if_data,
    output logic        dm_done,
    output logic [15:0] dm_rdata,
    output logic        if_stall,
    output logic        dm_stall
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    arb_state_e  state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic        flushed_q, flushed_d;
    logic [15:0] if_data_q, if_data_d;
    logic [15:0] dm_rdata_q, dm_rdata_d;

    logic        dm_win, if_win, launch;
    access_t     grant, lat_q;

    arb_latch u_latch (
        .clk (clk),
        .rst (rst),
        .en  (launch),
        .d   (grant),
        .q   (lat_q)
    );

    // Grant selection, next state, completion routing and data capture.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        flushed_d  = flushed_q;
        if_data_d  = if_data_q;
        dm_rdata_d = dm_rdata_q;
        dm_win     = 1'b0;
        if_win     = 1'b0;
        launch     = 1'b0;
        grant      = '0;
        if_done    = 1'b0;
        dm_done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                dm_win = dm_req & (~if_req | (starve_q < SW'(STARVE_LIMIT)));
                if_win = ~dm_win & if_req & ~if_flush;
                if (dm_win) begin
                    launch  = 1'b1;
                    grant   = '{rd: ~dm_wr, wr: dm_wr, addr: dm_addr, wdata: dm_wdata};
                    state_d = DM_BUSY;
                    // A DM win with IF waiting implies starve_q < limit, so this saturates.
                    starve_d = if_req ? starve_q + SW'(1) : '0;
                end else if (if_win) begin
                    launch   = 1'b1;
                    grant    = '{rd: 1'b1, wr: 1'b0, addr: if_addr, wdata: 16'h0};
                    state_d  = IF_BUSY;
                    starve_d = '0;
                end else if (!if_req) begin
                    starve_d = '0;
                end
            end
            IF_BUSY: begin
                if (mem_done) begin
                    state_d   = IDLE;
                    flushed_d = 1'b0;
                    // A redirect arriving with the completion also discards it.
                    if (!(flushed_q | if_flush)) begin
                        if_done   = 1'b1;
                        if_data_d = mem_rdata;
                    end
                end else if (if_flush) begin
                    flushed_d = 1'b1;
                end
            end
            DM_BUSY: begin
                if (mem_done) begin
                    state_d = IDLE;
                    dm_done = 1'b1;
                    if (lat_q.rd) dm_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            flushed_q  <= 1'b0;
            if_data_q  <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            flushed_q  <= flushed_d;
            if_data_q  <= if_data_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Launch drives the winner straight through; otherwise show the held access.
    always_comb begin
        mem_en    = launch;
        mem_wr    = launch ? grant.wr    : lat_q.wr;
        mem_addr  = launch ? grant.addr  : lat_q.addr;
        mem_wdata = launch ? grant.wdata : lat_q.wdata;
    end

    assign if_data  = if_data_q;
    assign dm_rdata = dm_rdata_q;
    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

endmodule
